// File: rtl/des_pkg.sv
// Shared widths, state encoding and shift table for the iterative DES key sequencer.
package des_pkg;

    localparam int unsigned KEY_W      = 64;
    localparam int unsigned CD_W       = 56;
    localparam int unsigned HALF_W     = 28;
    localparam int unsigned RK_W       = 48;
    localparam int unsigned NUM_ROUNDS = 16;
    localparam int unsigned IDX_W      = $clog2(NUM_ROUNDS);
    // Round number 1..NUM_ROUNDS (plus one spare code) needs one bit more than the beat index.
    localparam int unsigned K_W        = IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // s(k) == 2 for every round except 1, 2, 9 and 16 (which shift by 1).
    function automatic logic shift_is_two(input logic [K_W-1:0] k);
        return !((k == K_W'(1)) || (k == K_W'(2)) || (k == K_W'(9)) || (k == K_W'(16)));
    endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// Per-half C/D rotate by 1 or 2, left or right.
module des_cd_rotator
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_i,
    input  logic            left_i,
    input  logic            two_i,
    output logic [CD_W-1:0] cd_o
);

    function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] h,
                                              input logic left, input logic two);
        logic [HALF_W-1:0] r;
        if (left) begin
            r = two ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
        end else begin
            r = two ? {h[1:0], h[HALF_W-1:2]} : {h[0], h[HALF_W-1:1]};
        end
        return r;
    endfunction

    assign cd_o = {rot(cd_i[CD_W-1:HALF_W], left_i, two_i),
                   rot(cd_i[HALF_W-1:0],    left_i, two_i)};

endmodule

// File: rtl/pc1.sv
// DES permuted choice 1: 64-bit key to 56-bit C/D, dropping parity bits.
module pc1
    import des_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    output logic [CD_W-1:0]  cd_o
);

    // Entry i names the 1-based (MSB-first) key bit that lands in output bit i (MSB-first).
    localparam int unsigned TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 0; i < CD_W; i++) begin : g_bit
        assign cd_o[CD_W-1-i] = key_i[KEY_W-TAB[i]];
    end

    // Parity bits are intentionally discarded.
    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule

// File: rtl/pc2.sv
// DES permuted choice 2: 56-bit C/D to 48-bit round key.
module pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_i,
    output logic [RK_W-1:0] rk_o
);

    localparam int unsigned TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    for (genvar i = 0; i < RK_W; i++) begin : g_bit
        assign rk_o[RK_W-1-i] = cd_i[CD_W-TAB[i]];
    end

    // C/D bits 9, 18, 22, 25, 35, 38, 43, 54 never reach the round key.
    logic unused_cd;
    assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                         cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_sequencer.sv
// Iterative DES key schedule: one C/D register streams 16 round keys per loaded key.
module des_key_sequencer
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             decrypt,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             abort,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [RK_W-1:0]  round_key,
    output logic [IDX_W-1:0] round_idx,
    output logic             busy,
    output logic             done
);

    // cd_q always holds the C/D pair whose PC-2 is the key being presented, so the
    // round key can be registered straight from cd_d through a single PC-2.
    state_e           state_q, state_d;
    logic [CD_W-1:0]  cd_q, cd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             done_d;

    logic             key_ready_q, rk_valid_q, busy_q, done_q;
    logic [RK_W-1:0]  round_key_q;
    logic [IDX_W-1:0] round_idx_q;

    logic [CD_W-1:0]  pc1_cd, rot_in, rot_out;
    logic [RK_W-1:0]  rk_d;
    logic             rot_left, rot_two;
    logic [K_W-1:0]   rot_k;

    pc1 u_pc1 (.key_i(key_in), .cd_o(pc1_cd));

    des_cd_rotator u_rot (
        .cd_i   (rot_in),
        .left_i (rot_left),
        .two_i  (rot_two),
        .cd_o   (rot_out)
    );

    pc2 u_pc2 (.cd_i(cd_d), .rk_o(rk_d));

    // Rotator setup: load pre-rotates for K1; encrypt steps to C(idx+2); decrypt steps back.
    always_comb begin
        rot_in   = cd_q;
        rot_left = 1'b1;
        rot_k    = K_W'(idx_q) + K_W'(2);
        if (state_q == IDLE) begin
            rot_in = pc1_cd;
            rot_k  = K_W'(1);
        end else if (mode_q) begin
            rot_left = 1'b0;
            rot_k    = K_W'(NUM_ROUNDS) - K_W'(idx_q);
        end
        rot_two = shift_is_two(rot_k);
    end

    // Next-state: load, step on accept, abort with priority over both.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && key_valid) begin
                    state_d = RUN;
                    mode_d  = decrypt;
                    idx_d   = '0;
                    cd_d    = decrypt ? pc1_cd : rot_out;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cd_d    = '0;
                    idx_d   = '0;
                end else if (rk_ready) begin
                    if (idx_q == IDX_W'(NUM_ROUNDS - 1)) begin
                        state_d = IDLE;
                        cd_d    = '0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cd_d  = rot_out;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cd_q        <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_key_q <= '0;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            key_ready_q <= (state_d == IDLE);
            rk_valid_q  <= (state_d == RUN);
            busy_q      <= (state_d == RUN);
            done_q      <= done_d;
            round_key_q <= rk_d;
            round_idx_q <= idx_d;
        end
    end

    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// Randomised bench for des_key_sequencer against a transaction-level key schedule model.
module tb_des_key_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        key_valid = 1'b0;
    logic        abort = 1'b0;
    logic        rk_ready = 1'b0;
    logic        key_ready, rk_valid, busy, done;
    logic [47:0] round_key;
    logic [3:0]  round_idx;

    des_key_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .abort     (abort),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;

    int vectors = 0;
    int miscompares = 0;

    int pc1_t [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    int pc2_t [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Model: full schedule K1..K16 plus the current transaction position.
    logic [47:0] m_ks [0:16];
    bit          m_active = 1'b0;
    bit          m_dec = 1'b0;
    bit          m_done = 1'b0;
    int          m_beat = 0;

    logic [47:0] got [$];
    logic [47:0] enc_seq [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Textbook DES key schedule, written out directly from PC-1, shifts and PC-2.
    task automatic compute_ks(input logic [63:0] k);
        logic [55:0] cd;
        logic [55:0] t;
        logic [27:0] c, d;
        int sh;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        m_ks[0] = '0;
        for (int r = 1; r <= 16; r++) begin
            sh = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            c = (c << sh) | (c >> (28 - sh));
            d = (d << sh) | (d >> (28 - sh));
            t = {c, d};
            for (int j = 0; j < 48; j++) m_ks[r][47-j] = t[56-pc2_t[j]];
        end
    endtask

    function automatic logic [47:0] m_key();
        return m_dec ? m_ks[16-m_beat] : m_ks[m_beat+1];
    endfunction

    // Transaction tracker: advances on each accepted handshake at the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_beat   = 0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (key_valid && !abort) begin
                    compute_ks(key_in);
                    m_dec    = decrypt;
                    m_active = 1'b1;
                    m_beat   = 0;
                end
            end else if (abort) begin
                m_active = 1'b0;
                m_beat   = 0;
            end else if (rk_ready) begin
                if (m_beat == 15) begin
                    m_active = 1'b0;
                    m_beat   = 0;
                    m_done   = 1'b1;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    // Per-cycle compare against the model; also records every accepted key.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rk_valid", 64'(rk_valid), 64'(m_active));
            chk("key_ready", 64'(key_ready), 64'(!m_active));
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(m_done));
            if (m_active) begin
                chk("round_idx", 64'(round_idx), 64'(m_beat));
                chk("round_key", 64'(round_key), 64'(m_key()));
            end
            if (rk_valid && rk_ready && !abort) got.push_back(round_key);
        end
    end

    task automatic load(input logic [63:0] k, input logic dec);
        @(posedge clk); #1;
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input bit rand_ready);
        bit seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (rand_ready) rk_ready = ($urandom_range(0, 99) < 55);
        end
        chk(nm, 64'(seen), 64'(1));
    endtask

    initial begin
        int cyc;
        int errs;
        int cnt;
        bit kr, dn, hit;
        logic [63:0] k;
        logic dec;

        // Reset values
        repeat (2) @(posedge clk); #1;
        chk("rst_key_ready", 64'(key_ready), 64'(1));
        chk("rst_rk_valid", 64'(rk_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_round_key", 64'(round_key), 64'(0));
        chk("rst_round_idx", 64'(round_idx), 64'(0));
        @(negedge clk); rst_n = 1'b1;

        // Pin the model to published vectors
        compute_ks(KEY0);
        chk("model_k1", 64'(m_ks[1]), 64'h1B02EFFC7072);
        chk("model_k2", 64'(m_ks[2]), 64'h79AED9DBC9E5);
        chk("model_k16", 64'(m_ks[16]), 64'hCB3D8B0E17F5);

        // Encrypt at full rate
        rk_ready = 1'b1;
        got.delete();
        load(KEY0, 1'b0);
        cyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        chk("enc_done_cycle", 64'(cyc), 64'(17));
        chk("enc_count", 64'(got.size()), 64'(16));
        if (got.size() == 16) begin
            chk("enc_beat0", 64'(got[0]), 64'h1B02EFFC7072);
            chk("enc_beat15", 64'(got[15]), 64'hCB3D8B0E17F5);
            for (int i = 0; i < 16; i++) enc_seq[i] = got[i];
        end

        // Decrypt, same key: reversed sequence
        got.delete();
        load(KEY0, 1'b1);
        wait_done("dec_done_seen", 1'b0);
        chk("dec_count", 64'(got.size()), 64'(16));
        if (got.size() == 16) begin
            chk("dec_beat0", 64'(got[0]), 64'hCB3D8B0E17F5);
            chk("dec_beat15", 64'(got[15]), 64'h1B02EFFC7072);
            errs = 0;
            for (int i = 0; i < 16; i++) if (got[i] !== enc_seq[15-i]) errs++;
            chk("dec_reversed_errs", 64'(errs), 64'(0));
        end

        // Random keys and modes under random backpressure
        for (int it = 0; it < 6; it++) begin
            k   = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            if (it == 0) begin
                k   = KEY0;
                dec = 1'b0;
            end
            got.delete();
            rk_ready = 1'($urandom_range(0, 1));
            load(k, dec);
            wait_done("bp_done_seen", 1'b1);
            chk("bp_count", 64'(got.size()), 64'(16));
            errs = 0;
            for (int i = 0; i < 16 && i < got.size(); i++)
                if (got[i] !== (dec ? m_ks[16-i] : m_ks[i+1])) errs++;
            chk("bp_seq_errs", 64'(errs), 64'(0));
            if (it == 0 && got.size() == 16) begin
                errs = 0;
                for (int i = 0; i < 16; i++) if (got[i] !== enc_seq[i]) errs++;
                chk("bp_vs_nostall_errs", 64'(errs), 64'(0));
            end
        end

        // Abort at beat 7 together with rk_ready
        rk_ready = 1'b1;
        load(KEY0, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (rk_valid && round_idx == 4'd7) begin
                hit = 1'b1;
                abort = 1'b1;
                break;
            end
        end
        chk("abort_reached_beat7", 64'(hit), 64'(1));
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_rk_valid", 64'(rk_valid), 64'(0));
        chk("abort_key_ready", 64'(key_ready), 64'(1));
        chk("abort_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        chk("abort_no_late_done", 64'(done), 64'(0));
        load(KEY0, 1'b0);
        chk("reload_idx", 64'(round_idx), 64'(0));
        chk("reload_k1", 64'(round_key), 64'h1B02EFFC7072);
        wait_done("reload_done_seen", 1'b0);

        // Asynchronous reset mid-sequence
        load({$urandom, $urandom}, 1'b1);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rk_valid", 64'(rk_valid), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_round_key", 64'(round_key), 64'(0));
        chk("arst_round_idx", 64'(round_idx), 64'(0));
        chk("arst_key_ready", 64'(key_ready), 64'(1));
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_key_ready", 64'(key_ready), 64'(1));
        chk("post_rst_rk_valid", 64'(rk_valid), 64'(0));

        // Back-to-back: second key held from beat 10, opposite mode
        load(KEY0, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (rk_valid && round_idx == 4'd10) begin
                hit = 1'b1;
                break;
            end
        end
        chk("b2b_reached_beat10", 64'(hit), 64'(1));
        k = {$urandom, $urandom};
        key_in    = k;
        decrypt   = 1'b1;
        key_valid = 1'b1;
        cnt = 0;
        kr  = 1'b0;
        dn  = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            kr = key_ready;
            dn = done;
            @(posedge clk); #1;
            cnt++;
            if (kr) break;
        end
        key_valid = 1'b0;
        got.delete();
        chk("b2b_wait_cycles", 64'(cnt), 64'(7));
        chk("b2b_done_with_ready", 64'(dn), 64'(1));
        compute_ks(k);
        chk("b2b_first_key", 64'(round_key), 64'(m_ks[16]));
        chk("b2b_rk_valid", 64'(rk_valid), 64'(1));
        wait_done("b2b_done_seen", 1'b0);
        chk("b2b_count", 64'(got.size()), 64'(16));
        errs = 0;
        for (int i = 0; i < 16 && i < got.size(); i++) if (got[i] !== m_ks[16-i]) errs++;
        chk("b2b_seq_errs", 64'(errs), 64'(0));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_key_sequencer.md
Name: des_key_sequencer

Overview:
- Iterative DES round-key controller. It replaces the 16-copy unrolled key schedule with a single C/D register and one rotate/PC-2 path.
- Accepts a 64-bit key through a valid/ready handshake, then streams the 16 round keys one per accepted beat to the round engine.
- Round-key order is K1..K16 for encrypt and K16..K1 for decrypt.
- Sits between the key-load interface and an iterative DES round datapath; it reuses the existing pc1 and pc2 blocks.

Parameters:
- NUM_ROUNDS, 16, number of round keys per key load. Fixed for DES; drives the index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_in  input  64  DES key, parity bits ignored by PC-1
- decrypt  input  1  sampled with key_in: 0 = K1..K16, 1 = K16..K1
- key_valid  input  1  key load request
- key_ready  output  1  sequencer can accept a key (IDLE only)
- abort  input  1  synchronous cancel of the current sequence
- rk_ready  input  1  consumer accepts the presented round key
- rk_valid  output  1  round_key/round_idx valid
- round_key  output  48  current round key
- round_idx  output  4  beat number 0..15 (encrypt: round idx+1; decrypt: round 16-idx)
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse after the last key is accepted

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cd=0, idx=0, mode=0, rk_valid=0, busy=0, done=0, key_ready=1 after release; round_key=PC2(0)=0.
- Shift table s(k), k=1..16: s=1 for k in {1,2,9,16}, otherwise s=2. The sum of all shifts is 28.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: cd<=PC1(key_in), mode<=decrypt, idx<=0, go RUN.
  - Key-to-first-rk_valid latency is 1 cycle.
- RUN:
  - rk_valid=1, busy=1, key_ready=0.
  - Encrypt: round_key=PC2(rotl28(C,s(idx+1)),rotl28(D,s(idx+1))). On accept: cd<=rotl(cd,s(idx+1)).
  - Decrypt: round_key=PC2(C,D), with no shift (C16=C0). On accept: cd<=rotr(cd,s(16-idx)).
  - Rotations apply independently to each 28-bit half.
  - Accept = rk_valid&&rk_ready. On accept: idx<=idx+1. If idx==15: go IDLE and pulse done next cycle.
  - With rk_ready low, round_key, round_idx and rk_valid hold stable (standard valid/ready; no combinational dependence of rk_valid on rk_ready).
- Full-rate streaming: with rk_ready tied high, 16 keys arrive on 16 consecutive cycles and done is asserted on the 17th.
- Back-to-back loads:
  - key_ready rises in the same cycle as done; a new key is accepted then.
  - A key_valid held during RUN is not accepted and must wait.
- abort:
  - In RUN: go IDLE next cycle, drop rk_valid, no done pulse, cd/idx left don't-care (cleared to 0).
  - abort has priority over a simultaneous accept.
  - In IDLE: abort has priority over key_valid (no load).
- Reset mid-sequence: immediate return to reset values; no done pulse.
- round_idx wraps only via return to IDLE and never exceeds 15.
- done and rk_valid are never high together.

Decomposition:
- Shared package des_pkg:
  - Width constants KEY_W=64, CD_W=56, HALF_W=28, RK_W=48.
  - Shift-table function/constant array for s(k).
  - State enum {IDLE, RUN}.
- Sub-modules:
  - des_cd_rotator (combinational): 56-bit input, direction and amount 1/2 in, per-half rotate out. Used once.
  - Existing pc1 and pc2 instantiated once each.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, rk_ready=1 → beat0 round_key=0x1B02EFFC7072, beat15 round_key=0xCB3D8B0E17F5, idx 0..15 on consecutive cycles, done on cycle 17 after load.
- Decrypt, same key → beat0=0xCB3D8B0E17F5, beat15=0x1B02EFFC7072. All 16 beats equal the encrypt sequence reversed, checked against a reference model.
- Backpressure: random rk_ready pattern → round_key/round_idx stable while stalled, exactly 16 accepts, key sequence identical to the no-stall case.
- abort asserted at beat 7 together with rk_ready → rk_valid=0 next cycle, no done, key_ready=1. A new load then starts again from beat 0 with the correct K1.
- rst_n pulsed low asynchronously mid-sequence (between clock edges) → outputs go to reset values immediately. After release, key_ready=1 and no stale rk_valid.
- Back-to-back: second key_valid held from beat 10 → not accepted until the done cycle. The second sequence starts one cycle later, in the opposite mode, with correct keys.
